book_digit_loader: RTL and testbench
====================================

Name: book_digit_loader

Overview:
- Upstream feeder for the order-book display frame buffer: 2 rows (row 0 = bid, row 1 = ask) × NUM_DIGITS columns of 6-bit glyph codes.
- Accepts one binary quantity/price update per handshake.
- Converts it to decimal with a sequential double-dabble shifter.
- Streams the resulting glyph codes into the frame-buffer write port, one cell per cycle, most significant digit first.

Parameters:
- VALUE_W, 32, width of the binary update value.
- NUM_DIGITS, 10, decimal digits per row; also the column count.
- BLANK_GLYPH, 10, glyph code for an empty cell.
- ERR_GLYPH, 11, glyph code written to every cell of a row when the value overflows NUM_DIGITS.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- upd_valid  in  1  update request.
- upd_ready  out  1  block idle, can accept an update.
- upd_row  in  1  target row (0 bid, 1 ask).
- upd_value  in  VALUE_W  unsigned binary value.
- fb_we  out  1  frame-buffer write strobe.
- fb_row  out  1  row of current write.
- fb_col  out  4  column of current write (0 = leftmost = MSD).
- fb_data  out  6  glyph code (0-9 digit, BLANK_GLYPH, ERR_GLYPH).
- busy  out  1  conversion or write in progress.
- done  out  1  one-cycle pulse after last cell written.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, reset_n).
- Reset values: upd_ready=1, fb_we=0, fb_row=0, fb_col=0, fb_data=0, busy=0, done=0; FSM in IDLE; shift/BCD registers cleared.
- FSM states: IDLE, CONVERT, WRITE, DONE.
- IDLE:
  - upd_ready=1.
  - On upd_valid && upd_ready: latch upd_row and upd_value, clear the BCD register (NUM_DIGITS×4 bits) and overflow flag, go to CONVERT.
- CONVERT:
  - Runs exactly VALUE_W cycles; bit counter runs 0..VALUE_W-1.
  - Each cycle: add 3 to every BCD nibble ≥5, then shift {BCD, value} left 1.
  - A 1 shifted out of the top BCD nibble sets the sticky overflow flag.
  - After the final shift, go to WRITE with col=0.
- WRITE:
  - Exactly NUM_DIGITS cycles.
  - Each cycle: fb_we=1, fb_row=latched row, fb_col=col, fb_data=glyph(col); col increments.
  - After col=NUM_DIGITS-1, go to DONE.
- DONE: done=1 for one cycle, fb_we=0, then IDLE.
- Glyph rules:
  - overflow flag set → ERR_GLYPH in every column.
  - otherwise → BCD digit of that column, subject to leading-zero rule (Optional Feature).
- Latency: handshake at cycle T gives first fb_we at T+1+VALUE_W; last fb_we at T+VALUE_W+NUM_DIGITS; done at T+VALUE_W+NUM_DIGITS+1; upd_ready high again at T+VALUE_W+NUM_DIGITS+2.
- Status signals:
  - busy = (state≠IDLE).
  - upd_ready = (state==IDLE); combinational, never high while busy.
  - upd_valid outside IDLE is ignored (not queued); upstream must hold it until accepted.
- Input capture: upd_value/upd_row changes after acceptance have no effect.
- Reset mid-operation:
  - Abort immediately; fb_we=0 on the next cycle.
  - No further writes; partially written row stays as-is in the frame buffer.
- Value 0: BCD all zeros, no overflow.
- With defaults, no 32-bit value overflows (max 4294967295 fits 10 digits); overflow applies only to narrower NUM_DIGITS.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Every zero digit left of the most significant nonzero digit is written as BLANK_GLYPH.
  - Column NUM_DIGITS-1 is always a digit, so value 0 shows blanks then '0'.
  - Tracking is a 1-bit "seen nonzero" register cleared on entering WRITE.
- Undefined: all columns written with raw digits including leading zeros.
- Overflow (ERR_GLYPH) behaviour is identical either way.

Test Plan:
1. Reset (reset_n=0 for 2 cycles), release → upd_ready=1, busy=0, fb_we=0, done=0.
2. upd_row=0, upd_value=1234567890 → fb_we exactly 10 cycles starting 33 cycles after accept; (col,data) = (0,1),(1,2)…(8,9),(9,0); fb_row=0; done pulse 1 cycle after last write.
3. upd_row=1, upd_value=42:
   - with LEADING_ZERO_BLANK_EN → cols 0-7 = 10, col 8 = 4, col 9 = 2.
   - without → cols 0-7 = 0, then 4, 2.
   - value 0 with the macro → cols 0-8 = 10, col 9 = 0.
4. NUM_DIGITS=3, upd_value=1000 → cols 0-2 all ERR_GLYPH=11; upd_value=999 → 9,9,9.
5. Hold upd_valid high with a new value during busy → ignored; accepted again only after upd_ready returns; second row written correctly with no extra fb_we pulses.
6. Assert reset_n=0 during WRITE at col 4 → fb_we=0 from the next cycle, no done pulse, upd_ready=1 after release, new update processed normally.

Source files
------------

// File: rtl/book_digit_loader_if.sv
// Update handshake and frame-buffer write port for book_digit_loader.
// The slave modport is the loader; the master modport is the upstream/frame-buffer side.
interface book_digit_loader_if #(
    parameter int VALUE_W = 32
);
    logic               upd_valid;
    logic               upd_ready;
    logic               upd_row;
    logic [VALUE_W-1:0] upd_value;
    logic               fb_we;
    logic               fb_row;
    logic [3:0]         fb_col;
    logic [5:0]         fb_data;
    logic               busy;
    logic               done;

    modport master (
        output upd_valid, upd_row, upd_value,
        input  upd_ready, fb_we, fb_row, fb_col, fb_data, busy, done
    );

    modport slave (
        input  upd_valid, upd_row, upd_value,
        output upd_ready, fb_we, fb_row, fb_col, fb_data, busy, done
    );
endinterface

// File: rtl/book_digit_loader.sv
// Binary-to-decimal glyph loader for the order-book frame buffer (double-dabble, MSD first).
// Optional macro LEADING_ZERO_BLANK_EN blanks zeros left of the most significant nonzero digit.
module book_digit_loader #(
    parameter int VALUE_W     = 32,
    parameter int NUM_DIGITS  = 10,
    parameter int BLANK_GLYPH = 10,
    parameter int ERR_GLYPH   = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    book_digit_loader_if.slave bus
);

    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);
    localparam logic [3:0]       COL_LAST = 4'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

    state_t             state_r;
    state_t             state_next;
    logic               row_r;
    logic [VALUE_W-1:0] value_sr_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               ovf_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [3:0]         col_r;
    logic               fb_we_r;
    logic [5:0]         fb_data_r;
    logic               busy_r;
    logic               done_r;

    logic [BCD_W-1:0]   bcd_adj_s;
    logic [BCD_W-1:0]   bcd_shift_s;
    logic               carry_s;
    logic [BCD_W-1:0]   src_bcd_s;
    logic               src_ovf_s;
    logic [3:0]         next_col_s;
    logic [3:0]         digit_s;
    logic               blank_s;
    logic [5:0]         glyph_s;
`ifdef LEADING_ZERO_BLANK_EN
    logic               seen_r;
    logic               seen_in_s;
    logic               nonzero_s;
`endif

    // Add 3 to every nibble that is 5 or more, ahead of the left shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? (bcd[i*4 +: 4] + 4'd3) : bcd[i*4 +: 4];
        end
        return res;
    endfunction

    // Column 0 is the most significant nibble of the BCD register.
    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] bcd, input logic [3:0] col);
        int idx;
        if (int'(col) < NUM_DIGITS) begin
            idx = NUM_DIGITS - 1 - int'(col);
        end else begin
            idx = 0;
        end
        return bcd[idx*4 +: 4];
    endfunction

    function automatic logic [5:0] glyph_of(input logic [3:0] digit, input logic ovf, input logic blank);
        logic [5:0] g;
        if (ovf) begin
            g = 6'(ERR_GLYPH);
        end else if (blank) begin
            g = 6'(BLANK_GLYPH);
        end else begin
            g = {2'b00, digit};
        end
        return g;
    endfunction

    // Next-state logic for the load sequence.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:    if (bus.upd_valid)       state_next = CONVERT; else state_next = IDLE;
            CONVERT: if (cnt_r == CNT_LAST)   state_next = WRITE;   else state_next = CONVERT;
            WRITE:   if (col_r == COL_LAST)   state_next = DONE;    else state_next = WRITE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift step and glyph for the column written on the following cycle.
    always_comb begin
        bcd_adj_s   = dabble_adjust(bcd_r);
        bcd_shift_s = {bcd_adj_s[BCD_W-2:0], value_sr_r[VALUE_W-1]};
        carry_s     = bcd_adj_s[BCD_W-1];
        // On the last conversion cycle the glyph comes from the post-shift value.
        if (state_r == CONVERT) begin
            src_bcd_s  = bcd_shift_s;
            src_ovf_s  = ovf_r | carry_s;
            next_col_s = 4'd0;
        end else begin
            src_bcd_s  = bcd_r;
            src_ovf_s  = ovf_r;
            next_col_s = col_r + 4'd1;
        end
        digit_s = digit_at(src_bcd_s, next_col_s);
`ifdef LEADING_ZERO_BLANK_EN
        seen_in_s = (state_r == CONVERT) ? 1'b0 : seen_r;
        nonzero_s = (digit_s != 4'd0);
        blank_s   = !seen_in_s && !nonzero_s && (next_col_s != COL_LAST);
`else
        blank_s   = 1'b0;
`endif
        glyph_s = glyph_of(digit_s, src_ovf_s, blank_s);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            row_r      <= 1'b0;
            value_sr_r <= '0;
            bcd_r      <= '0;
            ovf_r      <= 1'b0;
            cnt_r      <= '0;
            col_r      <= 4'd0;
            fb_we_r    <= 1'b0;
            fb_data_r  <= 6'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            seen_r     <= 1'b0;
`endif
        end else begin
            state_r <= state_next;
            busy_r  <= (state_next != IDLE);
            done_r  <= (state_next == DONE);
            fb_we_r <= (state_next == WRITE);
            case (state_r)
                IDLE: begin
                    if (bus.upd_valid) begin
                        row_r      <= bus.upd_row;
                        value_sr_r <= bus.upd_value;
                        bcd_r      <= '0;
                        ovf_r      <= 1'b0;
                        cnt_r      <= '0;
                    end
                end
                CONVERT: begin
                    bcd_r      <= bcd_shift_s;
                    value_sr_r <= {value_sr_r[VALUE_W-2:0], 1'b0};
                    ovf_r      <= ovf_r | carry_s;
                    cnt_r      <= cnt_r + CNT_W'(1);
                end
                default: begin
                end
            endcase
            if (state_next == WRITE) begin
                col_r     <= next_col_s;
                fb_data_r <= glyph_s;
`ifdef LEADING_ZERO_BLANK_EN
                seen_r    <= seen_in_s | nonzero_s;
`endif
            end
        end
    end

    assign bus.upd_ready = (state_r == IDLE);
    assign bus.fb_we     = fb_we_r;
    assign bus.fb_row    = row_r;
    assign bus.fb_col    = col_r;
    assign bus.fb_data   = fb_data_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_book_digit_loader.sv
// Self-checking bench for book_digit_loader: vector table, random values vs a decimal model,
// busy-time valid hold, and reset during the write phase.
module tb_book_digit_loader;

    localparam int VW = 32;

    typedef logic [15:0][5:0] glyphs_t;
    typedef struct {
        int          sel;
        logic        row;
        logic [31:0] value;
        glyphs_t     exp;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    book_digit_loader_if #(.VALUE_W(VW)) ifa ();
    book_digit_loader_if #(.VALUE_W(VW)) ifb ();

    book_digit_loader #(.VALUE_W(VW), .NUM_DIGITS(10), .BLANK_GLYPH(10), .ERR_GLYPH(11)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa));
    book_digit_loader #(.VALUE_W(VW), .NUM_DIGITS(3), .BLANK_GLYPH(10), .ERR_GLYPH(11)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_we(input int s);    return (s == 1) ? ifb.fb_we     : ifa.fb_we;     endfunction
    function automatic logic m_row(input int s);   return (s == 1) ? ifb.fb_row    : ifa.fb_row;    endfunction
    function automatic logic [3:0] m_col(input int s);  return (s == 1) ? ifb.fb_col  : ifa.fb_col;  endfunction
    function automatic logic [5:0] m_data(input int s); return (s == 1) ? ifb.fb_data : ifa.fb_data; endfunction
    function automatic logic m_busy(input int s);  return (s == 1) ? ifb.busy      : ifa.busy;      endfunction
    function automatic logic m_done(input int s);  return (s == 1) ? ifb.done      : ifa.done;      endfunction
    function automatic logic m_ready(input int s); return (s == 1) ? ifb.upd_ready : ifa.upd_ready; endfunction

    task automatic drive(input int s, input logic v, input logic r, input logic [31:0] val);
        if (s == 1) begin
            ifb.upd_valid = v; ifb.upd_row = r; ifb.upd_value = val;
        end else begin
            ifa.upd_valid = v; ifa.upd_row = r; ifa.upd_value = val;
        end
    endtask

    // Decimal reference: plain division, overflow when value needs more than nd digits.
    function automatic glyphs_t model(input logic [31:0] v, input int nd);
        glyphs_t g;
        int      d[16];
        longint  lim;
        longint  x;
`ifdef LEADING_ZERO_BLANK_EN
        bit      seen;
`endif
        g   = '0;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        x = longint'({32'd0, v});
        if (x >= lim) begin
            for (int c = 0; c < nd; c++) g[c] = 6'd11;
            return g;
        end
        for (int c = nd - 1; c >= 0; c--) begin
            d[c] = int'(x % 10);
            x    = x / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        seen = 1'b0;
        for (int c = 0; c < nd; c++) begin
            if (d[c] != 0) seen = 1'b1;
            g[c] = (!seen && c != nd - 1) ? 6'd10 : 6'(d[c]);
        end
`else
        for (int c = 0; c < nd; c++) g[c] = 6'(d[c]);
`endif
        return g;
    endfunction

    // Offer one update, then check every cycle until upd_ready returns.
    task automatic do_txn(input int s, input logic row, input logic [31:0] val, input glyphs_t exp,
                          input bit hold, input logic h_row, input logic [31:0] h_val);
        int nd;
        int waited;
        bit in_w;
        nd = (s == 1) ? 3 : 10;
        drive(s, 1'b1, row, val);
        waited = 0;
        while (!m_ready(s) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", 32'(m_ready(s)), 32'd1);
        if (!m_ready(s)) begin
            drive(s, 1'b0, 1'b0, 32'd0);
            return;
        end
        @(negedge clk);
        if (hold) drive(s, 1'b1, h_row, h_val);
        else      drive(s, 1'b0, ~row, ~val);
        for (int k = 1; k <= VW + nd + 2; k++) begin
            in_w = (k >= VW + 1) && (k <= VW + nd);
            chk("fb_we", 32'(m_we(s)), 32'(in_w));
            if (in_w) begin
                chk("fb_col", 32'(m_col(s)), 32'(k - VW - 1));
                chk("fb_data", 32'(m_data(s)), 32'(exp[k - VW - 1]));
                chk("fb_row", 32'(m_row(s)), 32'(row));
            end
            chk("done", 32'(m_done(s)), 32'(k == VW + nd + 1));
            chk("busy", 32'(m_busy(s)), 32'(k <= VW + nd + 1));
            chk("upd_ready", 32'(m_ready(s)), 32'(k == VW + nd + 2));
            if (k < VW + nd + 2) @(negedge clk);
        end
    endtask

    vec_t    vecs[8];
    glyphs_t g_tmp;
    logic [31:0] rv;
    bit      found;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{0, 1'b0, 32'd1234567890,
                    {36'd0, 6'd0, 6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}};
        vecs[3] = '{0, 1'b1, 32'd4294967295,
                    {36'd0, 6'd5, 6'd9, 6'd2, 6'd7, 6'd6, 6'd9, 6'd4, 6'd9, 6'd2, 6'd4}};
        vecs[4] = '{1, 1'b0, 32'd1000, {78'd0, 6'd11, 6'd11, 6'd11}};
        vecs[5] = '{1, 1'b1, 32'd999,  {78'd0, 6'd9, 6'd9, 6'd9}};
        vecs[7] = '{1, 1'b1, 32'd4294967295, {78'd0, 6'd11, 6'd11, 6'd11}};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[1] = '{0, 1'b1, 32'd42, {36'd0, 6'd2, 6'd4, {8{6'd10}}}};
        vecs[2] = '{0, 1'b0, 32'd0,  {36'd0, 6'd0, {9{6'd10}}}};
        vecs[6] = '{1, 1'b0, 32'd7,  {78'd0, 6'd7, 6'd10, 6'd10}};
`else
        vecs[1] = '{0, 1'b1, 32'd42, {36'd0, 6'd2, 6'd4, 48'd0}};
        vecs[2] = '{0, 1'b0, 32'd0,  {36'd0, 6'd0, 54'd0}};
        vecs[6] = '{1, 1'b0, 32'd7,  {78'd0, 6'd7, 6'd0, 6'd0}};
`endif

        // Reset for two cycles, then release.
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ifa.upd_ready), 32'd1);
        chk("rst_busy",  32'(ifa.busy),      32'd0);
        chk("rst_we",    32'(ifa.fb_we),     32'd0);
        chk("rst_done",  32'(ifa.done),      32'd0);
        chk("rst_col",   32'(ifa.fb_col),    32'd0);
        chk("rst_data",  32'(ifa.fb_data),   32'd0);
        chk("rst_row",   32'(ifa.fb_row),    32'd0);
        chk("rst_b_ready", 32'(ifb.upd_ready), 32'd1);

        foreach (vecs[i]) begin
            do_txn(vecs[i].sel, vecs[i].row, vecs[i].value, vecs[i].exp, 1'b0, 1'b0, 32'd0);
        end

        // Valid held high with a new value while busy: taken only after upd_ready returns.
        do_txn(0, 1'b0, 32'd555, model(32'd555, 10), 1'b1, 1'b1, 32'd700001);
        do_txn(0, 1'b1, 32'd700001, model(32'd700001, 10), 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0:       rv = $urandom;
                1:       rv = 32'($urandom_range(0, 99999));
                default: rv = 32'($urandom_range(0, 20));
            endcase
            do_txn(0, 1'($urandom_range(0, 1)), rv, model(rv, 10), 1'b0, 1'b0, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            rv = 32'($urandom_range(0, 1500));
            do_txn(1, 1'($urandom_range(0, 1)), rv, model(rv, 3), 1'b0, 1'b0, 32'd0);
        end

        // Reset while column 4 is being written.
        drive(0, 1'b1, 1'b1, 32'd98765);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (ifa.fb_we && ifa.fb_col == 4'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_col4", 32'(found), 32'd1);
        reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_we",   32'(ifa.fb_we), 32'd0);
            chk("abort_done", 32'(ifa.done),  32'd0);
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_we",    32'(ifa.fb_we),     32'd0);
            chk("post_rst_done",  32'(ifa.done),      32'd0);
            chk("post_rst_ready", 32'(ifa.upd_ready), 32'd1);
            chk("post_rst_busy",  32'(ifa.busy),      32'd0);
        end
        g_tmp = model(32'd31415, 10);
        do_txn(0, 1'b0, 32'd31415, g_tmp, 1'b0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
